// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: FSM encoding and the
// per-segment bubble/flush control bundle.
package hazard_pkg;

    typedef enum logic [1:0] {
        DRAIN = 2'd0,
        RUN   = 2'd1,
        MISS  = 2'd2
    } hz_state_t;

    localparam int DEFAULT_DRAIN = 4;

    // Field order is shared with the segment registers; keep F..W, bubble before flush.
    typedef struct packed {
        logic bubbleF;
        logic flushF;
        logic bubbleD;
        logic flushD;
        logic bubbleE;
        logic flushE;
        logic bubbleM;
        logic flushM;
        logic bubbleW;
        logic flushW;
    } stage_ctrl_t;

    localparam stage_ctrl_t CTRL_NONE    = stage_ctrl_t'(10'b00_00_00_00_00);
    localparam stage_ctrl_t CTRL_DRAIN   = stage_ctrl_t'(10'b10_01_01_01_01);
    localparam stage_ctrl_t CTRL_MISS    = stage_ctrl_t'(10'b10_10_10_10_01);
    localparam stage_ctrl_t CTRL_BRANCH  = stage_ctrl_t'(10'b00_01_01_00_00);
    localparam stage_ctrl_t CTRL_LOADUSE = stage_ctrl_t'(10'b10_10_01_00_00);
    localparam stage_ctrl_t CTRL_JAL     = stage_ctrl_t'(10'b00_01_00_00_00);

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with asynchronous clear; holds at all-ones.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (en && (count != {CNT_W{1'b1}}))
            count <= count + {{(CNT_W-1){1'b0}}, 1'b1};
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: per-segment bubble/flush generation for the
// five-stage core, plus a saturating stall-cycle counter.
//
//   state | meaning
//   DRAIN | post-reset flush of downstream stages, hazard inputs ignored
//   RUN   | normal operation, priority-resolved hazards
//   MISS  | data-cache miss freeze until dcache_ready
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int DRAIN_CYCLES = DEFAULT_DRAIN,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs1_D,
    input  logic [4:0]       rs2_D,
    input  logic             rs1_used_D,
    input  logic             rs2_used_D,
    input  logic [4:0]       rd_E,
    input  logic             mem_read_E,
    input  logic             br_taken_E,
    input  logic             jalr_E,
    input  logic             jal_D,
    input  logic             dcache_miss,
    input  logic             dcache_ready,
    output logic             bubbleF,
    output logic             flushF,
    output logic             bubbleD,
    output logic             flushD,
    output logic             bubbleE,
    output logic             flushE,
    output logic             bubbleM,
    output logic             flushM,
    output logic             bubbleW,
    output logic             flushW,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    hz_state_t   state, state_nx;
    logic [DW-1:0] drain_cnt, drain_nx;
    stage_ctrl_t ctrl, run_ctrl;
    logic        load_use;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= DRAIN;
            drain_cnt <= DW'(DRAIN_CYCLES - 1);
        end else begin
            state     <= state_nx;
            drain_cnt <= drain_nx;
        end
    end

    assign load_use = mem_read_E && (rd_E != 5'd0) &&
                      ((rs1_used_D && (rs1_D == rd_E)) ||
                       (rs2_used_D && (rs2_D == rd_E)));

    // Rules shared by RUN (no pending miss) and the MISS release cycle.
    always_comb begin
        run_ctrl = CTRL_NONE;
        if (br_taken_E || jalr_E)
            run_ctrl = CTRL_BRANCH;
        else if (load_use)
            run_ctrl = CTRL_LOADUSE;
        else if (jal_D)
            run_ctrl = CTRL_JAL;
    end

    always_comb begin
        ctrl     = CTRL_DRAIN;
        state_nx = state;
        drain_nx = drain_cnt;
        unique case (state)
            DRAIN: begin
                ctrl = CTRL_DRAIN;
                if (drain_cnt == '0)
                    state_nx = RUN;
                else
                    drain_nx = drain_cnt - DW'(1);
            end
            RUN: begin
                if (dcache_miss && !dcache_ready) begin
                    ctrl     = CTRL_MISS;
                    state_nx = MISS;
                end else begin
                    ctrl = run_ctrl;
                end
            end
            MISS: begin
                if (dcache_ready) begin
                    ctrl     = run_ctrl;
                    state_nx = RUN;
                end else begin
                    ctrl = CTRL_MISS;
                end
            end
            default: begin
                ctrl     = CTRL_DRAIN;
                state_nx = DRAIN;
            end
        endcase
    end

    assign bubbleF = ctrl.bubbleF;
    assign flushF  = ctrl.flushF;
    assign bubbleD = ctrl.bubbleD;
    assign flushD  = ctrl.flushD;
    assign bubbleE = ctrl.bubbleE;
    assign flushE  = ctrl.flushE;
    assign bubbleM = ctrl.bubbleM;
    assign flushM  = ctrl.flushM;
    assign bubbleW = ctrl.bubbleW;
    assign flushW  = ctrl.flushW;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    ((state != DRAIN) && ctrl.bubbleF),
        .count (stall_cycles)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: vector table for single-cycle RUN hazards,
// hand sequences for drain, cache miss, async reset and counter saturation.
module tb_hazard_ctrl;

    logic       clk, rst;
    logic [4:0] rs1_D, rs2_D, rd_E;
    logic       rs1_used_D, rs2_used_D, mem_read_E, br_taken_E, jalr_E, jal_D;
    logic       dcache_miss, dcache_ready;

    logic bF, fF, bD, fD, bE, fE, bM, fM, bW, fW;
    logic [31:0] cnt;
    logic bF2, fF2, bD2, fD2, bE2, fE2, bM2, fM2, bW2, fW2;
    logic [2:0] cnt2;

    wire [9:0] ctl  = {bF, fF, bD, fD, bE, fE, bM, fM, bW, fW};
    wire [9:0] ctl2 = {bF2, fF2, bD2, fD2, bE2, fE2, bM2, fM2, bW2, fW2};

    localparam logic [9:0] P_NONE = 10'b0000000000;
    localparam logic [9:0] P_DRN  = 10'b1001010101;
    localparam logic [9:0] P_MISS = 10'b1010101001;
    localparam logic [9:0] P_BR   = 10'b0001010000;
    localparam logic [9:0] P_LU   = 10'b1010010000;
    localparam logic [9:0] P_JAL  = 10'b0001000000;

    int n_chk = 0;
    int n_fail = 0;

    hazard_ctrl #(.DRAIN_CYCLES(4), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .rs1_D(rs1_D), .rs2_D(rs2_D),
        .rs1_used_D(rs1_used_D), .rs2_used_D(rs2_used_D), .rd_E(rd_E),
        .mem_read_E(mem_read_E), .br_taken_E(br_taken_E), .jalr_E(jalr_E),
        .jal_D(jal_D), .dcache_miss(dcache_miss), .dcache_ready(dcache_ready),
        .bubbleF(bF), .flushF(fF), .bubbleD(bD), .flushD(fD), .bubbleE(bE),
        .flushE(fE), .bubbleM(bM), .flushM(fM), .bubbleW(bW), .flushW(fW),
        .stall_cycles(cnt)
    );

    hazard_ctrl #(.DRAIN_CYCLES(4), .CNT_W(3)) dut_sat (
        .clk(clk), .rst(rst), .rs1_D(rs1_D), .rs2_D(rs2_D),
        .rs1_used_D(rs1_used_D), .rs2_used_D(rs2_used_D), .rd_E(rd_E),
        .mem_read_E(mem_read_E), .br_taken_E(br_taken_E), .jalr_E(jalr_E),
        .jal_D(jal_D), .dcache_miss(dcache_miss), .dcache_ready(dcache_ready),
        .bubbleF(bF2), .flushF(fF2), .bubbleD(bD2), .flushD(fD2), .bubbleE(bE2),
        .flushE(fE2), .bubbleM(bM2), .flushM(fM2), .bubbleW(bW2), .flushW(fW2),
        .stall_cycles(cnt2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        string      name;
        logic [4:0] rs1, rs2, rd;
        logic       rs1u, rs2u, mr, br, jr, jal, miss, rdy;
        logic [9:0] exp_ctl;
        int         exp_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        rs1_D = 5'd0; rs2_D = 5'd0; rd_E = 5'd0;
        rs1_used_D = 1'b0; rs2_used_D = 1'b0; mem_read_E = 1'b0;
        br_taken_E = 1'b0; jalr_E = 1'b0; jal_D = 1'b0;
        dcache_miss = 1'b0; dcache_ready = 1'b0;
    endtask

    // Inputs change just after a rising edge.
    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mkv(input string n, input logic [4:0] rs1, input logic rs1u,
                                 input logic [4:0] rs2, input logic rs2u, input logic [4:0] rd,
                                 input logic mr, input logic br, input logic jr, input logic jal,
                                 input logic miss, input logic rdy, input logic [9:0] e, input int c);
        vec_t v;
        v.name = n; v.rs1 = rs1; v.rs1u = rs1u; v.rs2 = rs2; v.rs2u = rs2u; v.rd = rd;
        v.mr = mr; v.br = br; v.jr = jr; v.jal = jal; v.miss = miss; v.rdy = rdy;
        v.exp_ctl = e; v.exp_cnt = c;
        return v;
    endfunction

    initial begin
        //            name        rs1 u   rs2 u   rd  mr br jr jl ms rd  ctl     cnt
        vecs.push_back(mkv("idle",    0, 0,  0, 0,  0, 0, 0, 0, 0, 0, 0, P_NONE, 0));
        vecs.push_back(mkv("lu_rs2",  0, 0,  5, 1,  5, 1, 0, 0, 0, 0, 0, P_LU,   1));
        vecs.push_back(mkv("lu_rd0",  0, 1,  0, 1,  0, 1, 0, 0, 0, 0, 0, P_NONE, 1));
        vecs.push_back(mkv("lu_rs1",  7, 1,  3, 1,  7, 1, 0, 0, 0, 0, 0, P_LU,   2));
        vecs.push_back(mkv("rs1_unused", 7, 0, 3, 1, 7, 1, 0, 0, 0, 0, 0, P_NONE, 2));
        vecs.push_back(mkv("no_load", 9, 1,  9, 1,  9, 0, 0, 0, 0, 0, 0, P_NONE, 2));
        vecs.push_back(mkv("br_wins", 5, 1,  5, 1,  5, 1, 1, 0, 1, 0, 0, P_BR,   2));
        vecs.push_back(mkv("jalr",    0, 0,  0, 0,  0, 0, 0, 1, 0, 0, 0, P_BR,   2));
        vecs.push_back(mkv("jal",     0, 0,  0, 0,  0, 0, 0, 0, 1, 0, 0, P_JAL,  2));
        vecs.push_back(mkv("lu_over_jal", 4, 1, 0, 0, 4, 1, 0, 0, 1, 0, 0, P_LU, 3));
        vecs.push_back(mkv("miss_hit", 0, 0, 0, 0,  0, 0, 0, 0, 0, 1, 1, P_NONE, 3));
        vecs.push_back(mkv("miss_hit_jal", 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, P_JAL, 3));

        // Reset and drain
        idle_inputs();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ctl", 32'(ctl), 32'(P_DRN));
        chk("reset_cnt", cnt, 0);
        after_edge();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("drain_ctl%0d", i), 32'(ctl), 32'(P_DRN));
            after_edge();
        end
        @(negedge clk);
        chk("post_drain_ctl", 32'(ctl), 32'(P_NONE));
        chk("post_drain_cnt", cnt, 0);
        after_edge();

        // Single-cycle hazards in RUN
        foreach (vecs[i]) begin
            rs1_D = vecs[i].rs1; rs1_used_D = vecs[i].rs1u;
            rs2_D = vecs[i].rs2; rs2_used_D = vecs[i].rs2u;
            rd_E = vecs[i].rd; mem_read_E = vecs[i].mr;
            br_taken_E = vecs[i].br; jalr_E = vecs[i].jr; jal_D = vecs[i].jal;
            dcache_miss = vecs[i].miss; dcache_ready = vecs[i].rdy;
            @(negedge clk);
            chk({vecs[i].name, "_ctl"}, 32'(ctl), 32'(vecs[i].exp_ctl));
            after_edge();
            chk({vecs[i].name, "_cnt"}, cnt, 32'(vecs[i].exp_cnt));
        end

        // Cache miss: five frozen cycles, release on ready in the sixth
        idle_inputs();
        dcache_miss = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            br_taken_E   = (c == 3);
            dcache_ready = (c == 6);
            @(negedge clk);
            chk($sformatf("miss_c%0d_ctl", c), 32'(ctl), 32'((c == 6) ? P_NONE : P_MISS));
            after_edge();
        end
        chk("miss_cnt", cnt, 8);
        idle_inputs();
        @(negedge clk);
        chk("after_miss_ctl", 32'(ctl), 32'(P_NONE));
        after_edge();
        chk("after_miss_cnt", cnt, 8);

        // Async reset while frozen in MISS
        dcache_miss = 1'b1;
        after_edge();
        #1;
        chk("pre_rst_ctl", 32'(ctl), 32'(P_MISS));
        rst = 1'b1;
        #1;
        chk("async_rst_ctl", 32'(ctl), 32'(P_DRN));
        chk("async_rst_cnt", cnt, 0);
        chk("async_rst_cnt_sat", 32'(cnt2), 0);
        idle_inputs();
        after_edge();
        rst = 1'b0;
        repeat (3) after_edge();
        @(negedge clk);
        chk("rst_drain_last_ctl", 32'(ctl), 32'(P_DRN));
        after_edge();

        // Saturation on the 3-bit instance
        dcache_miss = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            chk($sformatf("sat_c%0d_ctl", k), 32'(ctl2), 32'(P_MISS));
            after_edge();
            chk($sformatf("sat_c%0d_cnt", k), 32'(cnt2), (k > 7) ? 7 : k);
        end
        chk("sat_wide_cnt", cnt, 10);
        dcache_ready = 1'b1;
        @(negedge clk);
        chk("sat_release_ctl", 32'(ctl2), 32'(P_NONE));
        after_edge();
        chk("sat_release_cnt", 32'(cnt2), 7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
